// File: rtl/pio_edge_in.sv
// pio_edge_in: parameterised Avalon-MM input PIO for the Nios II.
//
// Brings a WIDTH-bit asynchronous input port into the clk domain and
// captures per-bit edges with write-1-to-clear. A maskable level interrupt
// is provided. Optional per-bit debounce is enabled by defining the macro
// PIO_EDGE_IN_DEBOUNCE_EN.
//
// Register map (word address):
//   0 data        RO  zero-extended stable input value
//   1 reserved    RO  reads 0
//   2 irqmask     RW  per-bit interrupt enable
//   3 edgecapture RW1C per-bit captured edge
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        register select
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   in_port        asynchronous external inputs
//   readdata       registered read data, latency 1
//   irq            level interrupt, |(edgecapture & irqmask)
//
// Parameters:
//   WIDTH            input width, 1..32
//   EDGE_TYPE        0 rising, 1 falling, 2 any
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  stable cycles needed (debounce build only)
module pio_edge_in #(
  parameter int WIDTH           = 10,
  parameter int EDGE_TYPE       = 0,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Upper writedata bits have no register behind them.
  assign unused_wdata = ^writedata;

  // ---- Stage: input synchroniser ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign sync_q = sync_pipe[SYNC_STAGES-1];

  // Arm counter: edges are ignored until the synchroniser and prev_q hold
  // real input samples, so inputs already high at reset release are not
  // reported as edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_DONE) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed = (arm_cnt == ARM_DONE);

  // ---- Stage: optional debounce ----
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt [WIDTH];
  logic [WIDTH-1:0] deb_q;

  // A bit's accepted value changes only after sync_q has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the
  // count, so shorter glitches never reach the edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
    end else if (!armed) begin
      deb_q <= sync_q;
      for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb_q[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign stable = deb_q;
`else
  localparam int unused_deb_cycles = DEBOUNCE_CYCLES;

  assign stable = sync_q;
`endif

  // ---- Stage: edge detect ----
  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
    if (!armed) edge_det = '0;
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // ---- Stage: registers and read mux ----
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // A new edge takes priority over a software clear in the same cycle so
  // that an event arriving during the clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      prev_q      <= stable;
      edgecapture <= edge_det | (edgecapture & ~clr);
      readdata    <= rd_mux;
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_edge_in.sv
// Testbench for pio_edge_in: three instances (rising, falling, any edge)
// share one bus and one input port; a history-based reference model
// predicts readdata and irq of each instance every cycle.
module tb_pio_edge_in;

  localparam int W    = 10;
  localparam int S    = 2;
  localparam int D    = 8;
  localparam int MAXC = 4096;
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int LAT  = S + D + 1;
`else
  localparam int LAT  = S + 1;
`endif

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_v  [3];
  logic          irq_v [3];

  pio_edge_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[0]), .irq(irq_v[0]));

  pio_edge_in #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[1]), .irq(irq_v[1]));

  pio_edge_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_v[2]), .irq(irq_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in_hist[k] is the in_port sample taken at clock edge k
  // after reset release, stab_hist[k] the accepted input value after edge k.
  int           n;
  logic [W-1:0] in_hist   [MAXC];
  logic [W-1:0] stab_hist [MAXC];
  logic [W-1:0] m_cap     [3];
  logic [W-1:0] m_mask;
  logic [31:0]  m_rd      [3];

  // Synchronised value after edge k is the sample from S-1 edges earlier.
  function automatic logic [W-1:0] sync_at(input int k);
    if (k - S + 1 >= 1) return in_hist[k - S + 1];
    return '0;
  endfunction

  function automatic logic [W-1:0] stable_at(input int k);
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
    logic [W-1:0] v;
    logic [W-1:0] sj;
    bit           flip;
    if (k == 0) return '0;
    if (k - 1 < S + 1) return sync_at(k - 1);
    v = stab_hist[k - 1];
    if (k - D >= S + 1) begin
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int j = k - D; j < k; j++) begin
          sj = sync_at(j);
          if (sj[b] == v[b]) flip = 1'b0;
        end
        if (flip) v[b] = ~v[b];
      end
    end
    return v;
`else
    return sync_at(k);
`endif
  endfunction

  task automatic model_reset();
    n            = 0;
    in_hist[0]   = '0;
    stab_hist[0] = '0;
    m_mask       = '0;
    for (int e = 0; e < 3; e++) begin
      m_cap[e] = '0;
      m_rd[e]  = '0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] s1, s2, rise, fall, ed, clr;
    bit           wr;
    s1   = stab_hist[n];
    s2   = (n >= 1) ? stab_hist[n - 1] : '0;
    wr   = chipselect && !write_n;
    clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    rise = s1 & ~s2;
    fall = ~s1 & s2;
    for (int e = 0; e < 3; e++) begin
      case (address)
        2'd0:    m_rd[e] = 32'(s1);
        2'd2:    m_rd[e] = 32'(m_mask);
        2'd3:    m_rd[e] = 32'(m_cap[e]);
        default: m_rd[e] = '0;
      endcase
      ed = (e == 0) ? rise : (e == 1) ? fall : (rise | fall);
      if (n < S + 1) ed = '0;
      m_cap[e] = ed | (m_cap[e] & ~clr);
    end
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    n++;
    in_hist[n]   = in_port;
    stab_hist[n] = stable_at(n);
  endtask

  task automatic check_outputs();
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("readdata[%0d]", e), rd_v[e], m_rd[e]);
      chk($sformatf("irq[%0d]", e), {31'b0, irq_v[e]}, {31'b0, |(m_cap[e] & m_mask)});
    end
  endtask

  task automatic tick(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else          model_step();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = '1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    writedata  = '0;
    model_reset();
    tick(3);
    reset_n = 1'b1;

    // Inputs high across reset release: no capture, data reads all ones.
    tick(10);
`ifndef PIO_EDGE_IN_DEBOUNCE_EN
    chk("t1_edgecapture", rd_v[0], 32'h0);
`endif
    chk("t1_irq", {31'b0, irq_v[0]}, 32'h0);
    address = 2'd0;
    tick();
    chk("t1_data", rd_v[0], 32'h3FF);

    // Single rising edge, latency and masking.
    in_port = '0;
    address = 2'd3;
    tick(LAT + 1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(2);
    in_port = 10'h008;
    tick(LAT);
    chk("t2_cap_early", rd_v[0], 32'h0);
    tick();
    chk("t2_cap", rd_v[0], 32'h008);
    chk("t2_irq_masked", {31'b0, irq_v[0]}, 32'h0);
    bus_write(2'd2, 32'h8);
    address = 2'd3;
    chk("t2_irq_unmasked", {31'b0, irq_v[0]}, 32'h1);

    // Write-1-to-clear of individual bits.
    in_port = 10'h00C;
    tick(LAT + 1);
    chk("t3_cap", rd_v[0], 32'h00C);
    bus_write(2'd3, 32'h4);
    tick();
    chk("t3_cap_clr4", rd_v[0], 32'h008);
    chk("t3_irq_kept", {31'b0, irq_v[0]}, 32'h1);
    bus_write(2'd3, 32'h8);
    chk("t3_irq_drop", {31'b0, irq_v[0]}, 32'h0);
    tick();
    chk("t3_cap_clr8", rd_v[0], 32'h0);

    // Clear in the same cycle as a new edge: the edge wins.
    in_port = 10'h02C;
    tick(LAT + 1);
    chk("t4_cap_first", rd_v[0], 32'h020);
    in_port = 10'h00C;
    tick(LAT + 1);
    in_port = 10'h02C;
    tick(LAT - 1);
    bus_write(2'd3, 32'h20);
    tick();
    chk("t4_set_wins", rd_v[0], 32'h020);

    // Any-edge instance: both edges of a 20-cycle pulse are captured.
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick(2);
    in_port = 10'h02D;
    tick(LAT + 1);
    chk("t5_any_rise", rd_v[2] & 32'h1, 32'h1);
    bus_write(2'd3, 32'h1);
    tick();
    chk("t5_any_cleared", rd_v[2] & 32'h1, 32'h0);
    tick(20 - (LAT + 1) - 2);
    in_port = 10'h02C;
    tick(LAT + 1);
    chk("t5_any_fall", rd_v[2] & 32'h1, 32'h1);
    chk("t5_rise_no_fall", rd_v[0] & 32'h1, 32'h0);

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
    // Short glitch rejected, long pulse accepted after the debounce delay.
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd0;
    tick(2);
    in_port = 10'h02E;
    tick(5);
    in_port = 10'h02C;
    tick(15);
    chk("t6_glitch_data", rd_v[0] & 32'h2, 32'h0);
    address = 2'd3;
    tick();
    chk("t6_glitch_cap", rd_v[0], 32'h0);
    address = 2'd0;
    in_port = 10'h02E;
    tick(LAT - 1);
    chk("t6_data_early", rd_v[0] & 32'h2, 32'h0);
    tick();
    chk("t6_data", rd_v[0] & 32'h2, 32'h2);
    address = 2'd3;
    tick();
    chk("t6_cap", rd_v[0] & 32'h2, 32'h2);
    in_port = 10'h02C;
`endif

    // Randomised traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        reset_n = 1'b0;
        #1;
        for (int e = 0; e < 3; e++) begin
          chk($sformatf("async_rst_rd[%0d]", e), rd_v[e], 32'h0);
          chk($sformatf("async_rst_irq[%0d]", e), {31'b0, irq_v[e]}, 32'h0);
        end
        model_reset();
        tick(2);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) in_port ^= W'($urandom & $urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 7) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_edge_in.md
Name: pio_edge_in

Overview:
- Parametrised successor to the fixed-width read-only input PIO: Avalon-MM slave exposing a WIDTH-bit external input port to the Nios II.
- Adds:
  - input synchronisation
  - per-bit edge capture with write-1-to-clear
  - interrupt mask and an irq output
  - optional per-bit debounce
- Sits between board switches/buttons and the system interconnect.

Parameters:
- WIDTH, 10: input port width; legal range 1..32.
- EDGE_TYPE, 0: edge to capture; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles before a bit change is accepted; used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt request

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All flops reset to 0, so readdata = 0, irq = 0, irqmask = 0, edgecapture = 0.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit → sync_q.
- Stable value: stable = sync_q, or the debounced value when DEBOUNCE_EN is defined.
- Edge detect: prev_q <= stable every cycle.
  - rise = stable & ~prev_q
  - fall = ~stable & prev_q
  - edge = rise, fall or (rise | fall), selected by EDGE_TYPE.
- Arming after reset:
  - 3-bit arm counter counts 0 → SYNC_STAGES+1, then holds.
  - While the counter is below SYNC_STAGES+1, edge is forced to 0.
  - No spurious capture from inputs already high at reset release.
- Registers (wr = chipselect & ~write_n):
  - addr 0: data. Read returns zero-extended stable; writes ignored.
  - addr 1: reserved. Reads 0; writes ignored.
  - addr 2: irqmask[WIDTH-1:0]. R/W; wr loads writedata[WIDTH-1:0].
  - addr 3: edgecapture[WIDTH-1:0]. Read returns value; wr clears each bit where writedata bit = 1.
- edgecapture per bit: if edge then 1; else if clear then 0; else hold.
  - Set and clear in the same cycle → set wins (bit = 1).
  - A captured bit stays set until cleared by software, regardless of further edges.
- readdata:
  - Registered every clk from the address mux, independent of chipselect; read latency 1 cycle.
  - Bits 31..WIDTH are always 0.
  - A write to addr 2/3 is visible in readdata two cycles after the write cycle, if address is held.
- irq = |(edgecapture & irqmask), combinational from registers.
  - Asserts the cycle after the capturing edge is registered.
  - Deasserts the cycle after clear, or after the mask write.
- Latency: in_port change → edgecapture set = SYNC_STAGES+1 cycles (no debounce).
- Reset mid-operation: all state clears immediately; the arm sequence restarts.

Optional Feature:
- Macro: PIO_EDGE_IN_DEBOUNCE_EN.
- Defined, per bit:
  - Counter width = clog2(DEBOUNCE_CYCLES+1), plus a deb_q register.
  - If sync_q == deb_q, the counter clears.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1, deb_q <= sync_q and the counter clears.
  - While unarmed, deb_q <= sync_q directly.
  - stable = deb_q; added latency = DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected entirely.
- Undefined: no counters; stable = sync_q.

Test Plan:
1. Reset with in_port = 10'h3FF held high → after 10 cycles, edgecapture reads 0, irq = 0, addr 0 reads 32'h000003FF.
2. Defaults; in_port bit 3 rises 0→1 → edgecapture = 10'h008 at SYNC_STAGES+1 cycles. With irqmask = 0, irq stays 0. Write irqmask = 10'h008 → irq = 1 next cycle.
3. edgecapture = 10'h00C; write addr 3 with 32'h4 → reads 10'h008, irq still asserted. Write 32'h8 → reads 0, irq drops next cycle.
4. Clear of bit 5 issued in the same cycle as a new bit-5 edge → edgecapture bit 5 remains 1.
5. EDGE_TYPE = 2, bit 0 pulses high for 20 cycles → both edges set bit 0. Clear between the edges → bit set again by the falling edge.
6. PIO_EDGE_IN_DEBOUNCE_EN with DEBOUNCE_CYCLES = 8:
   - 5-cycle high glitch on bit 1 → no data change, no capture.
   - 12-cycle high → data bit 1 = 1 and capture after SYNC_STAGES+8+1 cycles.
